// File: rtl/fifo_reader_if.sv
// Handshake bundle between the FIFO read port, the fifo_reader skid buffer
// and the downstream consumer. The master side is the reader itself.
interface fifo_reader_if #(
   parameter int kWidth = 32
);
   logic              flush;
   logic              fifo_is_empty;
   logic              fifo_read_en;
   logic [kWidth-1:0] fifo_read_data;
   logic              out_valid;
   logic              out_ready;
   logic [kWidth-1:0] out_data;
   logic [1:0]        out_count;

   modport master (
      input  flush,
      input  fifo_is_empty,
      input  fifo_read_data,
      input  out_ready,
      output fifo_read_en,
      output out_valid,
      output out_data,
      output out_count
   );

   modport slave (
      output flush,
      output fifo_is_empty,
      output fifo_read_data,
      output out_ready,
      input  fifo_read_en,
      input  out_valid,
      input  out_data,
      input  out_count
   );
endinterface

// File: rtl/fifo_reader.sv
// Read-side adapter for the general-purpose FIFO. Pops entries into a
// 2-entry skid buffer and presents the oldest one on a registered
// valid/ready port. The read strobe depends only on registered occupancy,
// flush and the FIFO empty flag, so out_ready never reaches fifo_read_en
// combinationally. A flush empties the buffer and blocks reads that cycle.
module fifo_reader #(
   parameter int kWidth = 32
) (
   input  logic           clk,
   input  logic           rst,
   fifo_reader_if.master  bus
);

   logic [1:0]        count;
   logic [kWidth-1:0] entry0;
   logic [kWidth-1:0] entry1;
   logic              read;
   logic              pop;
   logic              has_entry;

   // Read/pop decisions and the visible outputs, all derived from registered state.
   always_comb begin
      has_entry = (count != 2'd0);
      read      = !rst && !bus.flush && !bus.fifo_is_empty && (count != 2'd2);
      pop       = has_entry && !bus.flush && bus.out_ready;
   end

   assign bus.fifo_read_en = read;
   assign bus.out_valid    = has_entry && !bus.flush;
   assign bus.out_data     = has_entry ? entry0 : '0;
   assign bus.out_count    = count;

   // Buffer update: entry0 is always the head, entry1 only fills when the head is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else if (bus.flush) begin
         count <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (read) begin
                  entry0 <= bus.fifo_read_data;
                  count  <= 2'd1;
               end
            end
            2'd1: begin
               if (read && !pop) begin
                  entry1 <= bus.fifo_read_data;
                  count  <= 2'd2;
               end else if (read && pop) begin
                  entry0 <= bus.fifo_read_data;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  entry0 <= entry1;
                  count  <= 2'd1;
               end
            end
            default: begin
               count <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: emulates the FIFO as an incrementing data source,
// records every read into an expected-entry queue, and a separate monitor
// checks occupancy, valid, read strobe and data order against that queue.
module tb_fifo_reader;
   localparam int kWidth = 32;

   logic clk = 1'b0;
   logic rst;

   fifo_reader_if #(.kWidth(kWidth)) bus ();

   fifo_reader #(.kWidth(kWidth)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [31:0] expQ[$];
   logic [31:0] nextVal;
   int avail;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Mirrors the FIFO read pointer: an accepted read hands the head over.
   task automatic recordRead();
      if (!rst && bus.fifo_read_en) begin
         expQ.push_back(bus.fifo_read_data);
         nextVal = nextVal + 1;
         if (avail > 0) avail--;
      end
   endtask

   task automatic applyStimulus(input bit f, input bit rdy, input int cycles, input int emptyPct);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         bus.flush          = f;
         bus.out_ready      = rdy;
         bus.fifo_is_empty  = (avail == 0) || ($urandom_range(99) < emptyPct);
         bus.fifo_read_data = nextVal;
         @(negedge clk);
         #1;
         recordRead();
      end
   endtask

   // Monitor: compares the DUT against the expected-entry queue each cycle.
   always @(negedge clk) begin
      int n;
      if (rst) begin
         checkOutput("rst_valid", {31'd0, bus.out_valid}, 32'd0);
         checkOutput("rst_count", {30'd0, bus.out_count}, 32'd0);
         checkOutput("rst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
         checkOutput("rst_data", bus.out_data, 32'd0);
         expQ.delete();
      end else begin
         n = expQ.size();
         checkOutput("count", {30'd0, bus.out_count}, n);
         checkOutput("valid", {31'd0, bus.out_valid}, {31'd0, (n != 0) && !bus.flush});
         checkOutput("read_en", {31'd0, bus.fifo_read_en},
                     {31'd0, !bus.flush && !bus.fifo_is_empty && (n < 2)});
         if (n == 0)
            checkOutput("idle_data", bus.out_data, 32'd0);
         else if (!bus.flush)
            checkOutput("data", bus.out_data, expQ[0]);
         if (bus.flush)
            expQ.delete();
         else if (n != 0 && bus.out_ready)
            void'(expQ.pop_front());
      end
   end

   initial begin
      rst                = 1'b1;
      bus.flush          = 1'b0;
      bus.out_ready      = 1'b0;
      bus.fifo_is_empty  = 1'b1;
      bus.fifo_read_data = '0;
      nextVal            = 32'h0;
      avail              = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming 0x11..0x18 with out_ready held high.
      nextVal = 32'h11;
      avail   = 8;
      applyStimulus(1'b0, 1'b1, 12, 0);

      // Backpressure: accept 0xA0, 0xA1, then stall, then resume.
      nextVal = 32'hA0;
      avail   = 6;
      applyStimulus(1'b0, 1'b1, 3, 0);
      applyStimulus(1'b0, 1'b0, 4, 0);
      applyStimulus(1'b0, 1'b1, 6, 0);

      // Flush with 0x5 and 0x6 buffered and the FIFO still non-empty.
      nextVal = 32'h5;
      avail   = -1;
      applyStimulus(1'b0, 1'b0, 3, 0);
      applyStimulus(1'b1, 1'b0, 1, 0);
      applyStimulus(1'b0, 1'b1, 4, 0);
      avail = 0;
      applyStimulus(1'b0, 1'b1, 3, 0);

      // Single entry 0x3C held under backpressure, then popped.
      nextVal = 32'h3C;
      avail   = 1;
      applyStimulus(1'b0, 1'b0, 11, 0);
      applyStimulus(1'b0, 1'b1, 3, 0);

      // Asynchronous reset in the middle of a cycle with two entries buffered.
      nextVal = 32'h70;
      avail   = -1;
      applyStimulus(1'b0, 1'b0, 3, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("async_rst_count", {30'd0, bus.out_count}, 32'd0);
      checkOutput("async_rst_data", bus.out_data, 32'd0);
      checkOutput("async_rst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
      @(posedge clk);
      #1;
      rst               = 1'b0;
      bus.fifo_is_empty = 1'b0;
      bus.out_ready     = 1'b1;
      #1;
      checkOutput("post_rst_read_en", {31'd0, bus.fifo_read_en}, 32'd1);
      @(negedge clk);
      #1;
      recordRead();
      applyStimulus(1'b0, 1'b1, 4, 0);

      // Random traffic: empty flag, ready and occasional flush.
      for (int c = 0; c < 10000; c++) begin
         applyStimulus(($urandom_range(39) == 0), $urandom_range(1), 1, 40);
      end

      avail = 0;
      applyStimulus(1'b0, 1'b1, 4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side adapter for the core's general-purpose FIFO: pops entries through the FIFO's read port and presents them downstream on a registered valid/ready interface through a 2-entry skid buffer. Used between instruction/uop queues and their consumers, such as the decode and issue stages. It gives full one-entry-per-cycle throughput with no combinational path from `out_ready` to `fifo_read_en`. It also supports a pipeline flush that discards buffered entries.

## Interface
- `kWidth`, default 32: entry width in bits; must match the attached FIFO.
- `clk` in, 1: clock; all state changes on the rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `flush` in, 1: discard all buffered entries; suppress FIFO reads this cycle.
- `fifo_is_empty` in, 1: FIFO empty flag.
- `fifo_read_en` out, 1: FIFO read strobe; the FIFO read pointer advances at the edge where this is high.
- `fifo_read_data` in, kWidth: FIFO head data, valid combinationally while `fifo_read_en` is high.
- `out_valid` out, 1: `out_data` holds a valid entry.
- `out_ready` in, 1: downstream accepts `out_data` this cycle.
- `out_data` out, kWidth: oldest buffered entry.
- `out_count` out, 2: number of buffered entries (0..2).

## Operation
- State
  - `count` is 2 bits, legal values 0, 1, 2. Value 3 is unreachable.
  - `entry0` is the head; `entry1` is the tail.
- Definitions
  - `pop = out_valid && out_ready`.
  - `fifo_read_en = !rst && !flush && !fifo_is_empty && (count != 2)`. This depends only on registered state, `flush` and `fifo_is_empty`, never on `out_ready`.
  - `out_valid = (count != 0) && !flush`.
  - `out_data = entry0` when `count != 0`, else 0.
  - `out_count = count`.
- Next state when `flush` = 0:
  - count 0, read: `entry0 <= fifo_read_data`; count becomes 1.
  - count 1, read and no pop: `entry1 <= fifo_read_data`; count becomes 2.
  - count 1, read and pop: `entry0 <= fifo_read_data`; count stays 1.
  - count 1, pop and no read: count becomes 0.
  - count 2, pop: `entry0 <= entry1`; count becomes 1. No read is possible at count 2.
  - No read and no pop: hold.
- Flush
  - `count <= 0`. Entry registers may keep stale data but are never visible.
  - `fifo_read_en` is 0 and `out_valid` is 0 during the flush cycle, so no entry is lost or delivered.
  - Flush has priority over every other event.
- Ordering: entries leave in exactly the order they were read from the FIFO. There is no duplication and no loss except by flush.
- Downstream may hold `out_ready` low indefinitely. `out_data` stays stable while `out_valid` is high and no pop occurs.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count = 0, entry0 = entry1 = 0.
  - out_valid = 0, out_data = 0, out_count = 0, fifo_read_en = 0.
- Reset released mid-stream: buffered entries are lost. The FIFO is reset in the same domain by its owner.
- Latency: an entry read at edge N is on `out_data` with `out_valid` = 1 in cycle N+1, i.e. one cycle from `fifo_read_en` to visibility.
- Throughput: with a non-empty FIFO and `out_ready` held at 1, the block sustains one read and one pop per cycle at count = 1.
- Backpressure: when `out_ready` drops, at most one further entry is read (count 1 → 2), then reads stop.
- After `out_ready` rises at count = 2:
  - first cycle: pop only (count 2 → 1);
  - following cycles: read resumes.
- FIFO empty while count > 0: the block keeps draining; `out_valid` drops after the last pop.
- FIFO going empty and non-empty in alternate cycles: each read is honoured independently, with no bubble beyond FIFO availability.

## Test plan
- **Reset:** assert `rst` mid-cycle with count = 2 → all outputs read 0 immediately. After release with `fifo_is_empty` = 0, `fifo_read_en` = 1 in the first cycle.
- **Streaming:** FIFO holds 0x11..0x18, `out_ready` = 1 → `out_data` shows 0x11..0x18 on 8 consecutive cycles starting one cycle after the first read. `out_count` stays 1, then goes to 0.
- **Backpressure:** stream 0xA0..0xA5 and drop `out_ready` after 0xA1 is accepted.
  - `fifo_read_en` falls once count = 2; entries 0xA2 and 0xA3 are buffered; `out_data` holds 0xA2.
  - Raise `out_ready` → order continues 0xA2, 0xA3, 0xA4, 0xA5 with no gap after the first pop.
- **Flush:** assert `flush` for one cycle at count = 2, with 0x5 and 0x6 buffered and the FIFO non-empty.
  - In the flush cycle: `out_valid` = 0 and `fifo_read_en` = 0.
  - Next cycle: count = 0, then reading restarts from the FIFO head. 0x5 and 0x6 never appear.
- **Empty boundary:** single entry 0x3C with `out_ready` = 0 → `out_valid` = 1 and `out_data` = 0x3C held for 10 cycles. Then pop → `out_valid` = 0 and `out_data` = 0.
- **Random:** 10k cycles of random `fifo_is_empty`, `out_ready` and occasional `flush`, checked against a scoreboard queue.
  - Check: in-order, lossless delivery between flushes.
  - Check: `fifo_read_en` is never high when `fifo_is_empty` = 1, when count = 2, or when `flush` = 1.
